// File: rtl/stage_muldiv_if.sv
// Request/response bundle between execute, the M-extension unit and mem.
// Ports: req_* (valid/ready request), kill, resp_* (valid/ready result), busy.
interface stage_muldiv_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            busy;

    modport master (
        output req_valid, req_op, req_a, req_b, kill, resp_ready,
        input  req_ready, resp_valid, resp_result, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, kill, resp_ready,
        output req_ready, resp_valid, resp_result, busy
    );
endinterface

// File: rtl/stage_muldiv.sv
// Multi-cycle RV M-extension unit (MUL*/DIV*/REM*), STEP bits per cycle.
// Ports: clk, reset (async, active-high), bus (stage_muldiv_if.slave).
module stage_muldiv #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input logic           clk,
    input logic           reset,
    stage_muldiv_if.slave bus
);
    localparam int ITERS = XLEN / STEP;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_nx;
    logic              neg_q;
    logic [CW-1:0]     count_q;
    logic [XLEN-1:0]   result_q;

    // Request decode, evaluated in IDLE at acceptance
    logic            op_div;
    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div0;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            neg_in;
    logic            accept;
    logic            last;

    assign op_div = bus.req_op[2];
    assign a_sgn  = (bus.req_op == 3'd1) || (bus.req_op == 3'd2) ||
                    (bus.req_op == 3'd4) || (bus.req_op == 3'd6);
    assign b_sgn  = (bus.req_op == 3'd1) || (bus.req_op == 3'd4) ||
                    (bus.req_op == 3'd6);
    assign a_neg  = a_sgn & bus.req_a[XLEN-1];
    assign b_neg  = b_sgn & bus.req_b[XLEN-1];
    assign a_mag  = a_neg ? -bus.req_a : bus.req_a;
    assign b_mag  = b_neg ? -bus.req_b : bus.req_b;

    assign div0 = op_div && (bus.req_b == '0);
    assign ovf  = op_div && !bus.req_op[0] &&
                  (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (bus.req_b == '1);
    assign special = div0 | ovf;

    // op[1] selects remainder among the divides
    always_comb begin
        special_res = '0;
        if (div0)
            special_res = bus.req_op[1] ? bus.req_a : '1;
        else
            special_res = bus.req_op[1] ? '0 : bus.req_a;
    end

    // Remainder follows the dividend; quotient/product follow a^b
    assign neg_in = (op_div && bus.req_op[1]) ? a_neg : (a_neg ^ b_neg);

    assign accept = (state == IDLE) && bus.req_valid && !bus.kill;
    assign last   = (state == CALC) && (count_q == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.kill) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.req_valid) state_nx = special ? DONE : CALC;
                CALC:    if (last) state_nx = DONE;
                DONE:    if (bus.resp_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // One iteration = STEP chained shift-add or restoring-subtract stages.
    // Multiply: acc = {partial, multiplier}, shifts right.
    // Divide:   acc = {remainder, dividend/quotient}, shifts left.
    logic [2*XLEN-1:0] work;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     diff;

    always_comb begin
        work = acc_q;
        sum  = '0;
        diff = '0;
        for (int i = 0; i < STEP; i++) begin
            if (op_q[2]) begin
                diff = work[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
                if (!diff[XLEN])
                    work = {diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
                else
                    work = {work[2*XLEN-2:0], 1'b0};
            end else begin
                sum  = {1'b0, work[2*XLEN-1:XLEN]} +
                       (work[0] ? {1'b0, opnd_q} : '0);
                work = {sum, work[XLEN-1:1]};
            end
        end
        acc_nx = work;
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        prod = neg_q ? -acc_nx : acc_nx;
        quo  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem  = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        if (op_q[2])
            fin_res = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'd0)
            fin_res = prod[XLEN-1:0];
        else
            fin_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= bus.req_op;
            opnd_q  <= op_div ? b_mag : a_mag;
            acc_q   <= {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
            neg_q   <= neg_in;
            count_q <= CW'(ITERS);
            if (special)
                result_q <= special_res;
        end else if ((state == CALC) && !bus.kill) begin
            acc_q   <= acc_nx;
            count_q <= count_q - CW'(1);
            if (last)
                result_q <= fin_res;
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.resp_valid  = (state == DONE);
    assign bus.resp_result = result_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_stage_muldiv.sv
// Self-checking bench for stage_muldiv (STEP=1 main unit, STEP=4 second unit).
// Ports: none; drives both units through stage_muldiv_if instances.
module tb_stage_muldiv;
    localparam int XLEN   = 32;
    localparam int ITERS1 = 32;
    localparam int ITERS4 = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    stage_muldiv_if #(.XLEN(XLEN)) bus ();
    stage_muldiv_if #(.XLEN(XLEN)) bus4 ();

    stage_muldiv #(.XLEN(XLEN), .STEP(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    stage_muldiv #(.XLEN(XLEN), .STEP(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic from the RV M-extension rules
    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input int iters);
        bit sp;
        sp = op[2] && ((b == 0) ||
             (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return sp ? 1 : iters + 1;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op on the STEP=1 unit; lat counts cycles from acceptance
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output logic [31:0] res);
        int n;
        lat = 0;
        res = '0;
        @(negedge clk);
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%0d", op);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        lat = 1;
        while (!bus.resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout op=%0d", op);
            return;
        end
        res = bus.resp_result;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid);
        end
        checks++;
        if (bus.resp_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result got=%h want=0", bus.resp_result);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got=%b want=1", bus.req_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        int          lat;
        logic [31:0] res;
        do_op(3'd0, 32'd3, 32'd5, lat, res);
        @(negedge clk);
        bus.req_op    = 3'd5;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd7;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_state busy=%b valid=%b want 0/0",
                     bus.busy, bus.resp_valid);
        end
        checks++;
        if (bus.resp_result !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_result got=%h want=0",
                     bus.resp_result);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [98:0] vec [13];
        logic [2:0]  op;
        logic [31:0] a, b, e, res;
        int          lat;
        vec = '{
            {3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            {3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
            {3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            {3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            {3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
            {3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
            {3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
            {3'd5, 32'd100,       32'd7,         32'd14},
            {3'd7, 32'd100,       32'd7,         32'd2},
            {3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
            {3'd7, 32'd5,         32'd0,         32'd5},
            {3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            {3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
        };
        for (int i = 0; i < 13; i++) begin
            {op, a, b, e} = vec[i];
            do_op(op, a, b, lat, res);
            checks++;
            if (res !== e) begin
                errors++;
                $display("FAIL directed_%0d op=%0d got=%h want=%h",
                         i, op, res, e);
            end
            checks++;
            if (lat != exp_lat(op, a, b, ITERS1)) begin
                errors++;
                $display("FAIL directed_lat_%0d got=%0d want=%0d",
                         i, lat, exp_lat(op, a, b, ITERS1));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            do_op(op, a, b, lat, res);
            checks++;
            if (res !== model(op, a, b) ||
                lat != exp_lat(op, a, b, ITERS1)) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h got=%h/%0d want=%h/%0d",
                         op, a, b, res, lat, model(op, a, b),
                         exp_lat(op, a, b, ITERS1));
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        @(negedge clk);
        bus.req_op     = 3'd5;
        bus.req_a      = 32'd1000;
        bus.req_b      = 32'd3;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd6;
        bus.req_b     = 32'd7;
        bus.req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                bus.resp_result !== model(3'd5, 32'd1000, 32'd3))
                bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold bad_cycles=%0d want=0 result=%h",
                     bad, bus.resp_result);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 ||
            bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle busy=%b ready=%b valid=%b want 0/1/0",
                     bus.busy, bus.req_ready, bus.resp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept busy=%b want=1", bus.busy);
        end
        n = 1;
        while (!bus.resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.resp_result !== 32'd42 || n != ITERS1 + 1) begin
            errors++;
            $display("FAIL bp_next got=%h/%0d want=%h/%0d",
                     bus.resp_result, n, 32'd42, ITERS1 + 1);
        end
        @(posedge clk);
    endtask

    task automatic test_kill();
        int          bad;
        int          lat;
        logic [31:0] res;
        @(negedge clk);
        bus.req_op     = 3'd4;
        bus.req_a      = $urandom;
        bus.req_b      = 32'($urandom_range(1, 1000));
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL kill_pre busy=%b want=1", bus.busy);
        end
        bus.kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle busy=%b valid=%b want 0/0",
                     bus.busy, bus.resp_valid);
        end
        bad = 0;
        for (int i = 0; i < ITERS1 + 4; i++) begin
            if (bus.resp_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL kill_no_resp cycles=%0d want=0", bad);
        end
        do_op(3'd0, 32'd3, 32'd5, lat, res);
        checks++;
        if (res !== 32'd15 || lat != ITERS1 + 1) begin
            errors++;
            $display("FAIL kill_then_mul got=%h/%0d want=%h/%0d",
                     res, lat, 32'd15, ITERS1 + 1);
        end
    endtask

    task automatic test_kill_idle();
        @(negedge clk);
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd9;
        bus.req_b     = 32'd9;
        bus.req_valid = 1'b1;
        bus.kill      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.kill      = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_accept busy=%b want=0", bus.busy);
        end
    endtask

    task automatic test_kill_done();
        int n;
        @(negedge clk);
        bus.req_op     = 3'd7;
        bus.req_a      = 32'd50;
        bus.req_b      = 32'd0;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd50) begin
            errors++;
            $display("FAIL kill_done_pre valid=%b res=%h want 1/%h",
                     bus.resp_valid, bus.resp_result, 32'd50);
        end
        bus.kill       = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_done valid=%b busy=%b want 0/0",
                     bus.resp_valid, bus.busy);
        end
    endtask

    task automatic test_step4();
        logic [2:0]  op;
        logic [31:0] a, b;
        int          n;
        int          bad;
        bad = 0;
        for (int i = 0; i < 21; i++) begin
            if (i == 0) begin
                op = 3'd0; a = 32'd3; b = 32'd5;
            end else begin
                op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
            end
            @(negedge clk);
            bus4.req_op    = op;
            bus4.req_a     = a;
            bus4.req_b     = b;
            bus4.req_valid = 1'b1;
            if (bus4.req_ready !== 1'b1) bad++;
            @(posedge clk);
            @(negedge clk);
            bus4.req_valid = 1'b0;
            n = 1;
            while (!bus4.resp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus4.resp_result !== model(op, a, b) ||
                n != exp_lat(op, a, b, ITERS4)) begin
                errors++;
                $display("FAIL step4 op=%0d a=%h b=%h got=%h/%0d want=%h/%0d",
                         op, a, b, bus4.resp_result, n, model(op, a, b),
                         exp_lat(op, a, b, ITERS4));
            end
            @(posedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL step4_ready not_ready=%0d want=0", bad);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.kill        = 1'b0;
        bus.resp_ready  = 1'b1;
        bus4.req_valid  = 1'b0;
        bus4.req_op     = '0;
        bus4.req_a      = '0;
        bus4.req_b      = '0;
        bus4.kill       = 1'b0;
        bus4.resp_ready = 1'b1;
        test_reset();
        test_async_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_kill();
        test_kill_idle();
        test_kill_done();
        test_step4();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_muldiv.md
Name: stage_muldiv

Overview:
- Parametrised multi-cycle RV M-extension unit for the execute stage. It succeeds the single-op iterative multiplier path.
- Handles MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU at configurable width and configurable bits retired per cycle.
- Uses a valid/ready request side driven by execute, a valid/ready response side stalled by mem, and a kill input for pipeline flush.

Parameters:
- XLEN, 32, operand and result width.
- STEP, 1, bits retired per iteration. Legal values: 1, 2, 4. XLEN % STEP must be 0.
- ITERS, XLEN/STEP, derived iteration count (localparam, not overridable).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute presents an operation.
- req_ready  out  1  unit can accept. High only in IDLE.
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a  in  XLEN  rs1 operand (multiplicand or dividend).
- req_b  in  XLEN  rs2 operand (multiplier or divisor).
- kill  in  1  flush: abort any operation in progress.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result (driven as ~mem_stall).
- resp_result  out  XLEN  result word.
- busy  out  1  state != IDLE. Used by execute to generate ex_stall.

Behaviour:
- Reset (async, any state): state=IDLE, resp_valid=0, resp_result=0, busy=0. All internal accumulators and counters are cleared.
- State machine has three states: IDLE, CALC, DONE.
- IDLE:
  - req_ready=1.
  - Accept when req_valid & ~kill: latch op, operand magnitudes, sign flags and result-sign; set count=ITERS; go to CALC.
  - Special divides go directly to DONE: divisor==0, or signed overflow (DIV/REM with a=most-negative, b=all-ones).
- CALC:
  - Multiply: unsigned shift-add, STEP multiplier bits per cycle, into a 2*XLEN accumulator.
  - Divide: restoring division, STEP quotient bits per cycle (STEP chained subtract stages).
  - count decrements each cycle. When count reaches 0, apply the sign correction and load resp_result the same edge, then go to DONE.
- DONE:
  - resp_valid=1, and resp_result is held stable until the cycle resp_valid & resp_ready.
  - On that handshake, go to IDLE the next edge.
  - No new request is accepted in DONE; back-to-back issue costs one IDLE cycle.
- Latency: with acceptance at edge T, resp_valid is high from T+ITERS+1 for normal ops and from T+1 for special divides.
- Sign and width rules:
  - MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
  - MULH treats a and b as signed. MULHSU treats a as signed and b as unsigned. MULHU and the U-divides treat both as unsigned.
  - Signed product is negated (two's complement over 2*XLEN) when the operand signs differ.
  - Quotient is negative when signs differ. Remainder takes the sign of the dividend.
- Special results:
  - Divide by zero: quotient = all ones, remainder = a.
  - Signed overflow: quotient = a (most-negative), remainder = 0.
- Kill:
  - In any state, the next edge goes to IDLE and resp_valid=0; no response is produced for the killed op.
  - kill with req_valid in the same IDLE cycle means no accept.
  - kill takes priority over the resp_ready handshake.
- resp_valid & resp_ready & kill in the same cycle: the result is treated as not delivered; the consumer must qualify it with its own flush.
- Operands are sampled only at acceptance. req_a/req_b may change afterwards without effect.

Test Plan:
- XLEN=32, STEP=1: MULH 0x80000000 × 0x80000000 accepted at T -> resp_valid at T+33, result 0x40000000. MUL with the same operands -> 0x00000000.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE. MUL -> 0x00000001.
- DIV 0xFFFFFFF9 / 0x00000002 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both at T+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Both at T+1.
- Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_valid and resp_result stable, req_ready=0. A request presented meanwhile is accepted only after the handshake plus one IDLE cycle.
- Kill at T+10 of a DIV -> IDLE at T+11, no resp_valid. A new MUL 3×5 is accepted next and returns 15. STEP=4 rebuild: the same MUL returns at T+9.
